// File: rtl/arena_if.sv
// Game-side bundle for the arena core: player controls, trail-memory lookup/write
// port, head positions, crash flags and scores.
interface arena_if;
   logic [2:0] Game_State;
   logic [1:0] Blue_dir, Red_dir;
   logic [7:0] blue_color, red_color;
   logic [7:0] Blue_X, Blue_Y, Red_X, Red_Y;
   logic [9:0] Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
   logic [7:0] Blue_Next_X, Blue_Next_Y, Red_Next_X, Red_Next_Y;
   logic       Trail_We;
   logic [7:0] Trail_X, Trail_Y, Trail_Color;
   logic       Blue_Crash, Red_Crash, Round_Over;
   logic [3:0] Blue_Score, Red_Score;

   modport master (
      input  Game_State, Blue_dir, Red_dir, blue_color, red_color,
      output Blue_X, Blue_Y, Red_X, Red_Y,
      output Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real,
      output Blue_Next_X, Blue_Next_Y, Red_Next_X, Red_Next_Y,
      output Trail_We, Trail_X, Trail_Y, Trail_Color,
      output Blue_Crash, Red_Crash, Round_Over, Blue_Score, Red_Score
   );

   modport slave (
      output Game_State, Blue_dir, Red_dir, blue_color, red_color,
      input  Blue_X, Blue_Y, Red_X, Red_Y,
      input  Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real,
      input  Blue_Next_X, Blue_Next_Y, Red_Next_X, Red_Next_Y,
      input  Trail_We, Trail_X, Trail_Y, Trail_Color,
      input  Blue_Crash, Red_Crash, Round_Over, Blue_Score, Red_Score
   );
endinterface

// File: rtl/arena.sv
// Two-player light-cycle arena: frame-tick movement, crash detection, trail writes, scoring.
// ARENA_WRAP_EN: when defined, heads wrap at the field edges instead of crashing into the wall.
module arena (
   input  logic      Clk,
   input  logic      Reset_Score_n,
   input  logic      frame_clk,
   arena_if.master   bus
);
   localparam logic [2:0] ST_PLAY      = 3'd1;
   localparam logic [2:0] ST_NEW_ROUND = 3'd4;
   localparam logic [7:0] X_MAX = 8'd159;
   localparam logic [7:0] Y_MAX = 8'd119;

   typedef enum logic [1:0] {WR_IDLE, WR_BLUE, WR_RED} wr_st_t;

   function automatic logic [15:0] step(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] dir);
      logic [7:0] nx, ny;
      nx = x;
      ny = y;
      case (dir)
         2'd0:    ny = y - 8'd1;
         2'd1:    nx = x + 8'd1;
         2'd2:    ny = y + 8'd1;
         default: nx = x - 8'd1;
      endcase
`ifdef ARENA_WRAP_EN
      if (dir == 2'd1 && x == X_MAX) nx = 8'd0;
      if (dir == 2'd3 && x == 8'd0)  nx = X_MAX;
      if (dir == 2'd2 && y == Y_MAX) ny = 8'd0;
      if (dir == 2'd0 && y == 8'd0)  ny = Y_MAX;
`endif
      return {nx, ny};
   endfunction

   logic       fs1, fs2, fs3, tick;
   logic [7:0] blue_x, blue_y, red_x, red_y;
   logic [7:0] b_nx, b_ny, r_nx, r_ny;
   logic       blue_crash, red_crash, round_over;
   logic [3:0] blue_score, red_score;
   logic       b_hit, r_hit, same_cell, red_moved;
   wr_st_t     wr_st;
   logic       trail_we;
   logic [7:0] trail_x, trail_y, trail_color;

   assign tick       = fs2 & ~fs3;
   assign round_over = blue_crash | red_crash;
   assign {b_nx, b_ny} = step(blue_x, blue_y, bus.Blue_dir);
   assign {r_nx, r_ny} = step(red_x, red_y, bus.Red_dir);

   // Wrapped coordinates are always in range, so the wall test never fires with wrap enabled.
   assign same_cell = (b_nx == r_nx) && (b_ny == r_ny);
   assign b_hit = (b_nx > X_MAX) || (b_ny > Y_MAX) || (bus.blue_color != 8'd0) || same_cell;
   assign r_hit = (r_nx > X_MAX) || (r_ny > Y_MAX) || (bus.red_color != 8'd0) || same_cell;

   always_ff @(posedge Clk or negedge Reset_Score_n) begin
      if (!Reset_Score_n) begin
         fs1         <= 1'b0;
         fs2         <= 1'b0;
         fs3         <= 1'b0;
         blue_x      <= 8'd40;
         blue_y      <= 8'd60;
         red_x       <= 8'd120;
         red_y       <= 8'd60;
         blue_crash  <= 1'b0;
         red_crash   <= 1'b0;
         blue_score  <= 4'd0;
         red_score   <= 4'd0;
         red_moved   <= 1'b0;
         wr_st       <= WR_IDLE;
         trail_we    <= 1'b0;
         trail_x     <= 8'd0;
         trail_y     <= 8'd0;
         trail_color <= 8'd0;
      end else begin
         fs1 <= frame_clk;
         fs2 <= fs1;
         fs3 <= fs2;

         // The write sequence for an accepted move runs to completion even if play is held.
         case (wr_st)
            WR_BLUE: begin
               wr_st       <= WR_RED;
               trail_we    <= red_moved;
               trail_x     <= red_x;
               trail_y     <= red_y;
               trail_color <= 8'h02;
            end
            WR_RED: begin
               wr_st    <= WR_IDLE;
               trail_we <= 1'b0;
            end
            default: trail_we <= 1'b0;
         endcase

         if (bus.Game_State == ST_NEW_ROUND) begin
            blue_x     <= 8'd40;
            blue_y     <= 8'd60;
            red_x      <= 8'd120;
            red_y      <= 8'd60;
            blue_crash <= 1'b0;
            red_crash  <= 1'b0;
            red_moved  <= 1'b0;
            wr_st      <= WR_IDLE;
            trail_we   <= 1'b0;
         end else if (bus.Game_State == ST_PLAY && tick && !round_over) begin
            if (!b_hit) begin
               blue_x <= b_nx;
               blue_y <= b_ny;
            end
            if (!r_hit) begin
               red_x <= r_nx;
               red_y <= r_ny;
            end
            blue_crash <= b_hit;
            red_crash  <= r_hit;
            if (r_hit && !b_hit && blue_score != 4'd9) blue_score <= blue_score + 4'd1;
            if (b_hit && !r_hit && red_score != 4'd9)  red_score  <= red_score + 4'd1;
            red_moved   <= !r_hit;
            wr_st       <= WR_BLUE;
            trail_we    <= !b_hit;
            trail_x     <= b_nx;
            trail_y     <= b_ny;
            trail_color <= 8'h01;
         end
      end
   end

   assign bus.Blue_X       = blue_x;
   assign bus.Blue_Y       = blue_y;
   assign bus.Red_X        = red_x;
   assign bus.Red_Y        = red_y;
   assign bus.Blue_X_real  = {blue_x, 2'b00};
   assign bus.Blue_Y_real  = {blue_y, 2'b00};
   assign bus.Red_X_real   = {red_x, 2'b00};
   assign bus.Red_Y_real   = {red_y, 2'b00};
   assign bus.Blue_Next_X  = b_nx;
   assign bus.Blue_Next_Y  = b_ny;
   assign bus.Red_Next_X   = r_nx;
   assign bus.Red_Next_Y   = r_ny;
   assign bus.Trail_We     = trail_we;
   assign bus.Trail_X      = trail_x;
   assign bus.Trail_Y      = trail_y;
   assign bus.Trail_Color  = trail_color;
   assign bus.Blue_Crash   = blue_crash;
   assign bus.Red_Crash    = red_crash;
   assign bus.Round_Over   = round_over;
   assign bus.Blue_Score   = blue_score;
   assign bus.Red_Score    = red_score;
endmodule

// File: tb/tb_arena.sv
// Directed bench for arena: reset, movement, trail writes, crashes, scoring, new round, hold.
module tb_arena;
   logic Clk = 1'b0;
   logic Reset_Score_n = 1'b0;
   logic frame_clk = 1'b0;
   int   tests = 0;
   int   fails = 0;

   arena_if bus ();
   arena dut (.Clk(Clk), .Reset_Score_n(Reset_Score_n), .frame_clk(frame_clk), .bus(bus));

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int bx, input int by, input int rx, input int ry);
      chk({tag, ".bx"}, 32'(bus.Blue_X), bx);
      chk({tag, ".by"}, 32'(bus.Blue_Y), by);
      chk({tag, ".rx"}, 32'(bus.Red_X), rx);
      chk({tag, ".ry"}, 32'(bus.Red_Y), ry);
   endtask

   // Returns at the negedge just after the move edge (blue write slot).
   task automatic tick_start();
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
   endtask

   task automatic tick_end();
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic quick_tick();
      tick_start();
      @(negedge Clk);
      tick_end();
   endtask

   task automatic new_round();
      bus.Game_State = 3'd4;
      @(negedge Clk);
      bus.Game_State = 3'd1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.Game_State = 3'd2;
      bus.Blue_dir   = 2'd0;
      bus.Red_dir    = 2'd0;
      bus.blue_color = 8'd0;
      bus.red_color  = 8'd0;
      repeat (3) @(negedge Clk);

      // reset state
      chk_pos("reset", 40, 60, 120, 60);
      chk("reset.bxr", 32'(bus.Blue_X_real), 160);
      chk("reset.bcr", 32'(bus.Blue_Crash), 0);
      chk("reset.rcr", 32'(bus.Red_Crash), 0);
      chk("reset.ro", 32'(bus.Round_Over), 0);
      chk("reset.bs", 32'(bus.Blue_Score), 0);
      chk("reset.rs", 32'(bus.Red_Score), 0);
      chk("reset.we", 32'(bus.Trail_We), 0);
      chk("reset.bny", 32'(bus.Blue_Next_Y), 59);
      Reset_Score_n = 1'b1;
      @(negedge Clk);

      // basic move and write sequence
      bus.Game_State = 3'd1;
      bus.Blue_dir   = 2'd1;
      bus.Red_dir    = 2'd3;
      @(negedge Clk);
      chk("mv.bnx", 32'(bus.Blue_Next_X), 41);
      chk("mv.rnx", 32'(bus.Red_Next_X), 119);
      tick_start();
      chk_pos("mv", 41, 60, 119, 60);
      chk("mv.bxr", 32'(bus.Blue_X_real), 164);
      chk("mv.we1", 32'(bus.Trail_We), 1);
      chk("mv.tx1", 32'(bus.Trail_X), 41);
      chk("mv.ty1", 32'(bus.Trail_Y), 60);
      chk("mv.tc1", 32'(bus.Trail_Color), 8'h01);
      @(negedge Clk);
      chk("mv.we2", 32'(bus.Trail_We), 1);
      chk("mv.tx2", 32'(bus.Trail_X), 119);
      chk("mv.ty2", 32'(bus.Trail_Y), 60);
      chk("mv.tc2", 32'(bus.Trail_Color), 8'h02);
      @(negedge Clk);
      chk("mv.we3", 32'(bus.Trail_We), 0);
      tick_end();

      // colors outside the tick cycle are ignored
      bus.blue_color = 8'hFF;
      bus.red_color  = 8'hFF;
      repeat (5) @(negedge Clk);
      bus.blue_color = 8'd0;
      bus.red_color  = 8'd0;
      quick_tick();
      chk_pos("ign", 42, 60, 118, 60);
      chk("ign.ro", 32'(bus.Round_Over), 0);

      // hold state freezes everything
      bus.Game_State = 3'd2;
      tick_start();
      chk("hold.we1", 32'(bus.Trail_We), 0);
      @(negedge Clk);
      chk("hold.we2", 32'(bus.Trail_We), 0);
      tick_end();
      chk_pos("hold", 42, 60, 118, 60);
      bus.Game_State = 3'd1;

      // red runs into a trail
      bus.red_color = 8'h01;
      tick_start();
      bus.red_color = 8'd0;
      chk_pos("rcr", 43, 60, 118, 60);
      chk("rcr.rc", 32'(bus.Red_Crash), 1);
      chk("rcr.bc", 32'(bus.Blue_Crash), 0);
      chk("rcr.ro", 32'(bus.Round_Over), 1);
      chk("rcr.bs", 32'(bus.Blue_Score), 1);
      chk("rcr.rs", 32'(bus.Red_Score), 0);
      chk("rcr.we1", 32'(bus.Trail_We), 1);
      chk("rcr.tx1", 32'(bus.Trail_X), 43);
      @(negedge Clk);
      chk("rcr.we2", 32'(bus.Trail_We), 0);
      tick_end();
      tick_start();
      chk("over.we", 32'(bus.Trail_We), 0);
      @(negedge Clk);
      tick_end();
      chk_pos("over", 43, 60, 118, 60);
      chk("over.bs", 32'(bus.Blue_Score), 1);

      // new round keeps scores
      bus.Game_State = 3'd4;
      @(negedge Clk);
      chk_pos("nr", 40, 60, 120, 60);
      chk("nr.ro", 32'(bus.Round_Over), 0);
      chk("nr.bs", 32'(bus.Blue_Score), 1);
      chk("nr.we", 32'(bus.Trail_We), 0);
      bus.Game_State = 3'd1;

      // head-on collision
      for (int i = 0; i < 39; i++) quick_tick();
      chk_pos("ho.pre", 79, 60, 81, 60);
      chk("ho.ro0", 32'(bus.Round_Over), 0);
      quick_tick();
      chk_pos("ho", 79, 60, 81, 60);
      chk("ho.bc", 32'(bus.Blue_Crash), 1);
      chk("ho.rc", 32'(bus.Red_Crash), 1);
      chk("ho.bs", 32'(bus.Blue_Score), 1);
      chk("ho.rs", 32'(bus.Red_Score), 0);

      // right wall
      new_round();
      bus.Blue_dir = 2'd2;
      bus.Red_dir  = 2'd0;
      quick_tick();
      chk_pos("wl.pre", 40, 61, 120, 59);
      bus.Blue_dir = 2'd1;
      for (int i = 0; i < 119; i++) begin
         bus.Red_dir = (i % 2 == 0) ? 2'd2 : 2'd0;
         quick_tick();
      end
      bus.Red_dir = 2'd0;
      chk("wl.bx159", 32'(bus.Blue_X), 159);
      chk("wl.ro0", 32'(bus.Round_Over), 0);
`ifdef ARENA_WRAP_EN
      chk("wl.bnx", 32'(bus.Blue_Next_X), 0);
      quick_tick();
      chk("wl.bx", 32'(bus.Blue_X), 0);
      chk("wl.bc", 32'(bus.Blue_Crash), 0);
      chk("wl.rs", 32'(bus.Red_Score), 0);
`else
      chk("wl.bnx", 32'(bus.Blue_Next_X), 160);
      quick_tick();
      chk("wl.bx", 32'(bus.Blue_X), 159);
      chk("wl.bc", 32'(bus.Blue_Crash), 1);
      chk("wl.rs", 32'(bus.Red_Score), 1);
`endif
      chk("wl.ry", 32'(bus.Red_Y), 59);

      // reset aborts a pending write sequence and clears scores
      new_round();
      bus.Blue_dir = 2'd1;
      bus.Red_dir  = 2'd3;
      tick_start();
      chk("ab.we1", 32'(bus.Trail_We), 1);
      Reset_Score_n = 1'b0;
      #1;
      chk("ab.we0", 32'(bus.Trail_We), 0);
      chk("ab.bs", 32'(bus.Blue_Score), 0);
      chk("ab.rs", 32'(bus.Red_Score), 0);
      chk_pos("ab", 40, 60, 120, 60);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_Score_n = 1'b1;
      @(negedge Clk);
      chk("ab.we2", 32'(bus.Trail_We), 0);
      repeat (3) @(negedge Clk);
      chk("ab.we3", 32'(bus.Trail_We), 0);
      chk_pos("ab.post", 40, 60, 120, 60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
